// File: rtl/VX_ag_tcu_pkg.sv
// Shared AG tensor-core-unit types plus the dispatch-arbiter tag and perf constants.
// Latency: n/a (types, constants and one constant function only).
// Backpressure: n/a.
// Contents: ag_tcu_exe_t (op to TCU), ag_tcu_res_t (TCU result),
//   AG_TCU_ARB_TAG_W(n) (tag width for n requesters), ag_tcu_arb_tag_t,
//   AG_TCU_ARB_PERF_W (perf counter width).
package VX_ag_tcu_pkg;

   typedef struct packed {
      logic [3:0]  op;
      logic [5:0]  wid;
      logic [31:0] src;
   } ag_tcu_exe_t;

   typedef struct packed {
      logic [5:0]  wid;
      logic [31:0] data;
   } ag_tcu_res_t;

   // Width of a requester index; a single requester still gets one bit.
   function automatic int AG_TCU_ARB_TAG_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Widest requester count the shared tag type is sized for.
   localparam int AG_TCU_ARB_MAX_REQS = 16;

   typedef logic [AG_TCU_ARB_TAG_W(AG_TCU_ARB_MAX_REQS)-1:0] ag_tcu_arb_tag_t;

   localparam int AG_TCU_ARB_PERF_W = 32;

endpackage

// File: rtl/ag_tcu_dispatch_arbiter_tag_fifo.sv
// In-order tag FIFO with first-word-fall-through head.
// Latency: a pushed entry is visible on head_o the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
// Ports: clk, reset (sync active-low), push_i/push_dat_i, pop_i, head_o,
//   count_o (0..DEPTH), full_o, empty_o.
module ag_tcu_tag_fifo
   import VX_ag_tcu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [W-1:0]           push_dat_i,
   input  logic                   pop_i,
   output logic [W-1:0]           head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once counted in.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/ag_tcu_dispatch_arbiter.sv
// Round-robin arbiter sharing one AG TCU among NUM_REQS requesters; results steered back by in-order tags.
// Latency: request fire in cycle N -> tcu_execute_valid in N+1; result path 0 cycles (combinational).
// Backpressure: issue stalls while the output register is held or MAX_OUTSTANDING tags are in flight.
// Ports: clk, reset (sync active-low); req_valid/req_data/req_ready (per requester);
//   tcu_execute_valid/data/ready; tcu_result_valid/data/ready; rsp_valid/rsp_data/rsp_ready.
// Optional: define AG_TCU_ARB_PERF_EN to add perf_issue_count and perf_stall_cycles.
module ag_tcu_dispatch_arbiter
   import VX_ag_tcu_pkg::*;
#(
   parameter int NUM_REQS        = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQS-1:0]        req_valid,
   input  ag_tcu_exe_t [NUM_REQS-1:0] req_data,
   output logic [NUM_REQS-1:0]        req_ready,
   output logic                       tcu_execute_valid,
   output ag_tcu_exe_t                tcu_execute_data,
   input  logic                       tcu_execute_ready,
   input  logic                       tcu_result_valid,
   input  ag_tcu_res_t                tcu_result_data,
   output logic                       tcu_result_ready,
   output logic [NUM_REQS-1:0]        rsp_valid,
   output ag_tcu_res_t                rsp_data,
   input  logic [NUM_REQS-1:0]        rsp_ready
`ifdef AG_TCU_ARB_PERF_EN
   ,
   output logic [NUM_REQS-1:0][AG_TCU_ARB_PERF_W-1:0] perf_issue_count,
   output logic [AG_TCU_ARB_PERF_W-1:0]               perf_stall_cycles
`endif
);

   localparam int TAG_W = AG_TCU_ARB_TAG_W(NUM_REQS);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             exe_vld_q, exe_vld_d;
   ag_tcu_exe_t      exe_dat_q, exe_dat_d;

   logic [TAG_W-1:0] win_idx;
   logic             win_vld;
   logic             can_issue;
   logic             accept;

   logic [TAG_W-1:0] head_tag;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             res_fire;

   // Winner: first valid requester scanning upward from rr_ptr, wrapping at NUM_REQS.
   always_comb begin
      int               idx;
      logic [TAG_W-1:0] cand;
      idx     = 0;
      cand    = '0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQS) idx = idx - NUM_REQS;
         cand = TAG_W'(idx);
         if (!win_vld && req_valid[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Occupancy uses the registered count only, so a same-cycle pop cannot open a full FIFO.
   // Issue is also held off while reset is asserted.
   assign can_issue = reset && (!exe_vld_q || tcu_execute_ready)
                      && (fifo_count < CNT_W'(MAX_OUTSTANDING));
   assign accept    = win_vld && can_issue;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win_idx] = 1'b1;
   end

   // Output register: load on accept, clear on fire, otherwise hold.
   always_comb begin
      exe_vld_d = exe_vld_q;
      exe_dat_d = exe_dat_q;
      rr_ptr_d  = rr_ptr_q;
      if (accept) begin
         exe_vld_d = 1'b1;
         exe_dat_d = req_data[win_idx];
         rr_ptr_d  = (win_idx == TAG_W'(NUM_REQS - 1)) ? '0 : win_idx + TAG_W'(1);
      end else if (tcu_execute_ready) begin
         exe_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr_q  <= '0;
         exe_vld_q <= 1'b0;
         exe_dat_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         exe_vld_q <= exe_vld_d;
         exe_dat_q <= exe_dat_d;
      end
   end

   assign tcu_execute_valid = exe_vld_q;
   assign tcu_execute_data  = exe_dat_q;

   ag_tcu_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .W     (TAG_W)
   ) u_tag_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (accept),
      .push_dat_i (win_idx),
      .pop_i      (res_fire),
      .head_o     (head_tag),
      .count_o    (fifo_count),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // Result steering: the oldest tag names the owner of the in-order TCU result.
   always_comb begin
      rsp_valid = '0;
      if (tcu_result_valid && !fifo_empty) rsp_valid[head_tag] = 1'b1;
   end

   assign rsp_data         = tcu_result_data;
   assign tcu_result_ready = !fifo_empty && rsp_ready[head_tag];
   assign res_fire         = tcu_result_valid && tcu_result_ready;

`ifdef AG_TCU_ARB_PERF_EN
   logic [NUM_REQS-1:0][AG_TCU_ARB_PERF_W-1:0] issue_cnt_q;
   logic [AG_TCU_ARB_PERF_W-1:0]               stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (accept) issue_cnt_q[win_idx] <= issue_cnt_q[win_idx] + AG_TCU_ARB_PERF_W'(1);
         if (|req_valid && !can_issue) stall_cnt_q <= stall_cnt_q + AG_TCU_ARB_PERF_W'(1);
      end
   end

   assign perf_issue_count  = issue_cnt_q;
   assign perf_stall_cycles = stall_cnt_q;
`else
   // Counters are not built in this configuration.
`endif

   // A result with no outstanding tag means the TCU and the arbiter disagree on in-flight ops.
   assert property (@(posedge clk) disable iff (!reset) tcu_result_valid |-> !fifo_empty)
      else $error("tcu result arrived with no outstanding tag");

   // Issue is gated on the registered count, so the FIFO must never see a push while full.
   assert property (@(posedge clk) disable iff (!reset) !(accept && fifo_full))
      else $error("tag push while full");

endmodule
